// File: rtl/piece_motion_ctrl_pkg.sv
// Shared types, widths and mask helpers for the falling-piece controller.
package piece_motion_ctrl_pkg;

    localparam int COL_W = 4;
    localparam int ROW_W = 5;

    typedef logic [COL_W-1:0]        col_t;
    typedef logic [ROW_W-1:0]        row_t;
    typedef logic [8:0]              mask_t;
    // Candidate positions carry two extra bits so col-1 / row+1 can leave the board.
    typedef logic signed [COL_W+1:0] cand_col_t;
    typedef logic signed [ROW_W+1:0] cand_row_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DECIDE = 3'd2,
        ST_LOCK   = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    // Lower code = higher service priority among the pending commands.
    typedef enum logic [2:0] {
        CMD_SPAWN = 3'd0,
        CMD_DROP  = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_ROT   = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5
    } cmd_e;

    // Mask bit i sits at column offset dx = i/3 - 1.
    function automatic logic signed [1:0] mask_dx(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: return 2'sb11;
            4'd3, 4'd4, 4'd5: return 2'sb00;
            4'd6, 4'd7, 4'd8: return 2'sb01;
            default:          return 2'sb00;
        endcase
    endfunction

    // Mask bit i sits at row offset dy = i%3 - 1.
    function automatic logic signed [1:0] mask_dy(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: return 2'sb11;
            4'd1, 4'd4, 4'd7: return 2'sb00;
            4'd2, 4'd5, 4'd8: return 2'sb01;
            default:          return 2'sb00;
        endcase
    endfunction

    // Clockwise rotation: offset (dx,dy) moves to (-dy,dx).
    function automatic mask_t rotate_cw(input mask_t m);
        return {m[6], m[3], m[0], m[7], m[4], m[1], m[8], m[5], m[2]};
    endfunction

endpackage

// File: rtl/piece_motion_ctrl_collision_scan.sv
// Walks the nine mask cells of a candidate placement and reports whether any
// of them is off the board or already occupied. One cycle per cell, two when
// the occupancy RAM has to be read.
module piece_collision_scan
    import piece_motion_ctrl_pkg::*;
#(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic      clock,
    input  logic      resetn,
    input  logic      start,
    input  cand_col_t cand_col,
    input  cand_row_t cand_row,
    input  mask_t     cand_mask,
    output logic      occ_rd_en,
    output col_t      occ_rd_col,
    output row_t      occ_rd_row,
    input  logic      occ_rd_data,
    output logic      done,
    output logic      blocked
);

    localparam cand_col_t COLS_S = cand_col_t'(COLS);
    localparam cand_row_t ROWS_S = cand_row_t'(ROWS);

    logic        r_active;
    logic        r_wait;
    logic [3:0]  r_idx;
    logic        r_done;
    logic        r_blocked;

    logic signed [1:0] w_dx;
    logic signed [1:0] w_dy;
    cand_col_t   w_tcol;
    cand_row_t   w_trow;
    logic        w_bit;
    logic        w_oob;
    logic        w_row_neg;
    logic        w_last;
    logic        w_need_read;

    // Target cell of the mask bit currently under inspection.
    always_comb begin
        w_dx        = mask_dx(r_idx);
        w_dy        = mask_dy(r_idx);
        w_tcol      = cand_col + cand_col_t'(w_dx);
        w_trow      = cand_row + cand_row_t'(w_dy);
        w_bit       = cand_mask[r_idx];
        w_oob       = w_tcol[COL_W+1] || (w_tcol >= COLS_S) || (w_trow >= ROWS_S);
        w_row_neg   = w_trow[ROW_W+1];
        w_last      = (r_idx == 4'd8);
        w_need_read = r_active && !r_wait && w_bit && !w_oob && !w_row_neg;
    end

    // Read port is a pure decode of flops so it collapses as soon as resetn drops.
    assign occ_rd_en  = w_need_read;
    assign occ_rd_col = w_need_read ? w_tcol[COL_W-1:0] : col_t'(0);
    assign occ_rd_row = w_need_read ? w_trow[ROW_W-1:0] : row_t'(0);
    assign done       = r_done;
    assign blocked    = r_blocked;

    // Scan sequencer: advance, wait for RAM data, or finish with a verdict.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_active  <= 1'b0;
            r_wait    <= 1'b0;
            r_idx     <= 4'd0;
            r_done    <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (start) begin
                    r_active <= 1'b1;
                    r_wait   <= 1'b0;
                    r_idx    <= 4'd0;
                end
            end else if (r_wait) begin
                r_wait <= 1'b0;
                if (occ_rd_data || w_last) begin
                    r_active  <= 1'b0;
                    r_done    <= 1'b1;
                    r_blocked <= occ_rd_data;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end else if (!w_bit || (!w_oob && w_row_neg)) begin
                if (w_last) begin
                    r_active  <= 1'b0;
                    r_done    <= 1'b1;
                    r_blocked <= 1'b0;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end else if (w_oob) begin
                r_active  <= 1'b0;
                r_done    <= 1'b1;
                r_blocked <= 1'b1;
            end else begin
                r_wait <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/piece_motion_ctrl.sv
// Falling-piece sequencer: owns position and mask, serves spawn/gravity/user
// commands through a collision scan, and emits a lock pulse on landing.
module piece_motion_ctrl
    import piece_motion_ctrl_pkg::*;
#(
    parameter int SIZE          = 16,
    parameter int FIELD_X0      = 0,
    parameter int FIELD_Y0      = 0,
    parameter int COLS          = 10,
    parameter int ROWS          = 20,
    parameter int SPAWN_COL     = 4,
    parameter int GRAVITY_TICKS = 25000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       spawn_req,
    input  logic [8:0] spawn_mask,
    input  logic       cmd_left,
    input  logic       cmd_right,
    input  logic       cmd_rot,
    input  logic       cmd_drop,
    output logic       occ_rd_en,
    output logic [3:0] occ_rd_col,
    output logic [4:0] occ_rd_row,
    input  logic       occ_rd_data,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic [8:0] blockNeighbors,
    output logic       piece_active,
    output logic       busy,
    output logic       lock_valid,
    output logic [3:0] lock_col,
    output logic [4:0] lock_row,
    output logic [8:0] lock_mask,
    output logic       game_over
);

    localparam logic [31:0] GRAV_LAST = 32'(GRAVITY_TICKS - 1);

    function automatic logic [9:0] col_px(input col_t c);
        return 10'(FIELD_X0) + 10'(c) * 10'(SIZE);
    endfunction

    function automatic logic [9:0] row_px(input row_t r);
        return 10'(FIELD_Y0) + 10'(r) * 10'(SIZE);
    endfunction

    state_e      r_state, w_next_state;
    cmd_e        r_cmd, w_issue_cmd;
    logic        w_issue;
    cand_col_t   r_cand_col, w_issue_col, w_cur_col;
    cand_row_t   r_cand_row, w_issue_row, w_cur_row;
    mask_t       r_cand_mask, w_issue_mask;
    logic        r_scan_start;
    logic        w_scan_done, w_scan_blocked;
    logic        w_commit, w_enter_lock;

    col_t        r_col;
    row_t        r_row;
    mask_t       r_mask;
    logic        r_active;
    logic [9:0]  r_ref_x, r_ref_y;
    logic        r_lock_valid;
    col_t        r_lock_col;
    row_t        r_lock_row;
    mask_t       r_lock_mask;
    logic        r_busy, r_game_over;
    logic        r_pend_down, r_pend_rot, r_pend_left, r_pend_right, r_pend_drop;
    logic [31:0] r_grav_cnt;
    logic        w_grav_wrap;
    logic        w_idle_issue;

    assign w_cur_col    = {2'b00, r_col};
    assign w_cur_row    = {2'b00, r_row};
    assign w_grav_wrap  = r_active && (r_state != ST_OVER) && (r_grav_cnt == GRAV_LAST);
    assign w_idle_issue = w_issue && (r_state == ST_IDLE);

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, candidate selection and commit/lock strobes.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_issue_cmd  = CMD_SPAWN;
        w_issue_col  = w_cur_col;
        w_issue_row  = w_cur_row;
        w_issue_mask = r_mask;
        w_commit     = 1'b0;
        w_enter_lock = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_active) begin
                    if (spawn_req) begin
                        w_issue      = 1'b1;
                        w_issue_cmd  = CMD_SPAWN;
                        w_issue_col  = cand_col_t'(SPAWN_COL);
                        w_issue_row  = 7'sd1;
                        w_issue_mask = spawn_mask;
                    end else begin
                        w_issue = 1'b0;
                    end
                end else if (r_pend_drop) begin
                    w_issue     = 1'b1;
                    w_issue_cmd = CMD_DROP;
                    w_issue_row = w_cur_row + 7'sd1;
                end else if (r_pend_down) begin
                    w_issue     = 1'b1;
                    w_issue_cmd = CMD_DOWN;
                    w_issue_row = w_cur_row + 7'sd1;
                end else if (r_pend_rot) begin
                    w_issue      = 1'b1;
                    w_issue_cmd  = CMD_ROT;
                    w_issue_mask = rotate_cw(r_mask);
                end else if (r_pend_left) begin
                    w_issue     = 1'b1;
                    w_issue_cmd = CMD_LEFT;
                    w_issue_col = w_cur_col - 6'sd1;
                end else if (r_pend_right) begin
                    w_issue     = 1'b1;
                    w_issue_cmd = CMD_RIGHT;
                    w_issue_col = w_cur_col + 6'sd1;
                end else begin
                    w_issue = 1'b0;
                end
                if (w_issue) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (w_scan_done) begin
                    w_next_state = ST_DECIDE;
                end else begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_DECIDE: begin
                if (!w_scan_blocked) begin
                    w_commit = 1'b1;
                    if (r_cmd == CMD_DROP) begin
                        // Keep falling: probe the next row from the just-committed spot.
                        w_issue      = 1'b1;
                        w_issue_cmd  = CMD_DROP;
                        w_issue_col  = r_cand_col;
                        w_issue_row  = r_cand_row + 7'sd1;
                        w_issue_mask = r_cand_mask;
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else if (r_cmd == CMD_SPAWN) begin
                    w_next_state = ST_OVER;
                end else if ((r_cmd == CMD_DOWN) || (r_cmd == CMD_DROP)) begin
                    w_enter_lock = 1'b1;
                    w_next_state = ST_LOCK;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOCK: w_next_state = ST_IDLE;
            ST_OVER: w_next_state = ST_OVER;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Latch the candidate under test and fire the scan start strobe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cmd        <= CMD_SPAWN;
            r_cand_col   <= cand_col_t'(SPAWN_COL);
            r_cand_row   <= 7'sd1;
            r_cand_mask  <= 9'h000;
            r_scan_start <= 1'b0;
        end else if (w_issue) begin
            r_cmd        <= w_issue_cmd;
            r_cand_col   <= w_issue_col;
            r_cand_row   <= w_issue_row;
            r_cand_mask  <= w_issue_mask;
            r_scan_start <= 1'b1;
        end else begin
            r_scan_start <= 1'b0;
        end
    end

    // Piece position/mask: commit on a free scan, clear on lock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_col    <= col_t'(SPAWN_COL);
            r_row    <= row_t'(1);
            r_mask   <= 9'h000;
            r_active <= 1'b0;
            r_ref_x  <= col_px(col_t'(SPAWN_COL));
            r_ref_y  <= row_px(row_t'(1));
        end else if (w_commit) begin
            r_col   <= r_cand_col[COL_W-1:0];
            r_row   <= r_cand_row[ROW_W-1:0];
            r_mask  <= r_cand_mask;
            r_ref_x <= col_px(r_cand_col[COL_W-1:0]);
            r_ref_y <= row_px(r_cand_row[ROW_W-1:0]);
            if (r_cmd == CMD_SPAWN) begin
                r_active <= 1'b1;
            end
        end else if (w_enter_lock) begin
            r_mask   <= 9'h000;
            r_active <= 1'b0;
        end
    end

    // One-cycle lock pulse carrying the landed piece.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lock_valid <= 1'b0;
            r_lock_col   <= col_t'(0);
            r_lock_row   <= row_t'(0);
            r_lock_mask  <= 9'h000;
        end else begin
            r_lock_valid <= w_enter_lock;
            if (w_enter_lock) begin
                r_lock_col  <= r_col;
                r_lock_row  <= r_row;
                r_lock_mask <= r_mask;
            end
        end
    end

    // Pending command flags: lock clears all, new pulses win over service.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend_down  <= 1'b0;
            r_pend_rot   <= 1'b0;
            r_pend_left  <= 1'b0;
            r_pend_right <= 1'b0;
            r_pend_drop  <= 1'b0;
        end else if (w_enter_lock) begin
            r_pend_down  <= 1'b0;
            r_pend_rot   <= 1'b0;
            r_pend_left  <= 1'b0;
            r_pend_right <= 1'b0;
            r_pend_drop  <= 1'b0;
        end else begin
            r_pend_down  <= (r_active && w_grav_wrap) ||
                            (r_pend_down && !(w_idle_issue && (w_issue_cmd == CMD_DOWN)));
            r_pend_rot   <= (r_active && cmd_rot) ||
                            (r_pend_rot && !(w_idle_issue && (w_issue_cmd == CMD_ROT)));
            r_pend_left  <= (r_active && cmd_left) ||
                            (r_pend_left && !(w_idle_issue && (w_issue_cmd == CMD_LEFT)));
            r_pend_right <= (r_active && cmd_right) ||
                            (r_pend_right && !(w_idle_issue && (w_issue_cmd == CMD_RIGHT)));
            r_pend_drop  <= (r_active && cmd_drop) || r_pend_drop;
        end
    end

    // Gravity timer: restarts on spawn, raises a down request on wrap.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_grav_cnt <= 32'd0;
        end else if (w_commit && (r_cmd == CMD_SPAWN)) begin
            r_grav_cnt <= 32'd0;
        end else if (r_active && (r_state != ST_OVER)) begin
            r_grav_cnt <= w_grav_wrap ? 32'd0 : (r_grav_cnt + 32'd1);
        end
    end

    // Status flags follow the state being entered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_busy      <= (w_next_state == ST_CHECK) || (w_next_state == ST_DECIDE);
            r_game_over <= (w_next_state == ST_OVER);
        end
    end

    piece_collision_scan #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_scan (
        .clock       (clock),
        .resetn      (resetn),
        .start       (r_scan_start),
        .cand_col    (r_cand_col),
        .cand_row    (r_cand_row),
        .cand_mask   (r_cand_mask),
        .occ_rd_en   (occ_rd_en),
        .occ_rd_col  (occ_rd_col),
        .occ_rd_row  (occ_rd_row),
        .occ_rd_data (occ_rd_data),
        .done        (w_scan_done),
        .blocked     (w_scan_blocked)
    );

    assign ref_x          = r_ref_x;
    assign ref_y          = r_ref_y;
    assign blockNeighbors = r_mask;
    assign piece_active   = r_active;
    assign busy           = r_busy;
    assign lock_valid     = r_lock_valid;
    assign lock_col       = r_lock_col;
    assign lock_row       = r_lock_row;
    assign lock_mask      = r_lock_mask;
    assign game_over      = r_game_over;

endmodule

// File: doc/piece_motion_ctrl.md
Name: piece_motion_ctrl

Overview:
Sequences the single falling piece drawn by the pixel-level shape renderer. Owns the piece reference point and the 9-bit 3x3 neighbour mask, and drives them to the renderer as ref_x/ref_y/blockNeighbors. Handles spawn, gravity, left/right/rotate/hard-drop commands and collision checks against the board occupancy RAM. Emits a one-cycle lock event when the piece lands.

Parameters:
SIZE, 16, cell edge in pixels
FIELD_X0, 0, pixel x of board column 0
FIELD_Y0, 0, pixel y of board row 0
COLS, 10, board columns (max 16)
ROWS, 20, board rows (max 32)
SPAWN_COL, 4, spawn centre column (spawn centre row is fixed at 1)
GRAVITY_TICKS, 25000000, clock cycles per gravity step

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
spawn_req  in  1  pulse: spawn new piece
spawn_mask  in  9  neighbour mask of new piece
cmd_left / cmd_right / cmd_rot / cmd_drop  in  1 each  command pulses
occ_rd_en  out  1  occupancy read strobe
occ_rd_col  out  4  read column
occ_rd_row  out  5  read row
occ_rd_data  in  1  occupied flag; valid the cycle after occ_rd_en
ref_x / ref_y  out  10 each  pixel reference of centre cell
blockNeighbors  out  9  current mask to renderer
piece_active  out  1  piece on board
busy  out  1  collision check in progress
lock_valid  out  1  one-cycle lock pulse
lock_col / lock_row / lock_mask  out  4/5/9  locked piece; valid with lock_valid
game_over  out  1  sticky until reset

Behaviour:
- Mask bit i means cell offset dx = i/3-1, dy = i%3-1. Bit 4 is the centre.
- ref_x = FIELD_X0 + col*SIZE, ref_y = FIELD_Y0 + row*SIZE. Computed in 10 bits; no wrap is possible within the parameter limits.
- Reset values: col = SPAWN_COL, row = 1, mask 0, piece_active 0, busy 0, occ_rd_en 0, lock_valid 0, game_over 0, all pending flags 0, gravity counter 0.
- Pending flags: one each for down, rot, left, right and drop. A pending flag is set by its command pulse (or by a gravity wrap for down) in any cycle while piece_active is 1. Repeats coalesce. A flag clears when its command is served.
- Gravity counter: runs only while piece_active=1 and state is not OVER. At GRAVITY_TICKS-1 it wraps to 0 and sets pend_down.
- FSM IDLE:
  - If !piece_active and spawn_req: candidate = (SPAWN_COL, 1, spawn_mask); go to CHECK.
  - Else, with piece_active, serve the highest-priority pending flag in the order drop > down > rot > left > right.
  - Candidates: down = row+1; left = col-1; right = col+1; rot = mask rotated clockwise, offset (dx,dy) -> (-dy,dx).
- FSM CHECK: the sub-module scans mask bits 0..8.
  - A clear bit costs 1 cycle.
  - A target cell with col<0, col>=COLS or row>=ROWS is blocked immediately (1 cycle).
  - A target cell with row<0 is free (1 cycle).
  - Otherwise assert occ_rd_en for one cycle and sample occ_rd_data the next cycle (2 cycles).
  - The scan aborts at the first blocked cell. busy=1 throughout.
- FSM DECIDE:
  - Free: commit the candidate to col/row/mask; on spawn, set piece_active=1 and clear the gravity counter.
  - Blocked spawn: go to OVER.
  - Blocked down: go to LOCK.
  - Blocked left/right/rot: discard, state unchanged.
  - Drop: re-issue down candidates until one is blocked, then go to LOCK. pend_drop clears at lock.
- FSM LOCK:
  - lock_valid=1 for exactly one cycle with the current col/row/mask.
  - piece_active becomes 0, mask becomes 0, all pending flags clear.
  - Return to IDLE.
- FSM OVER: game_over=1, all inputs ignored, exit only via resetn.
- spawn_req while piece_active=1 is ignored. Commands while !piece_active are ignored.
- resetn low at any point, including mid-CHECK: all outputs take reset values asynchronously and occ_rd_en drops immediately.

Decomposition:
- Shared package holds: the mask index/offset mapping, a rotate_cw function, the state enum, command-priority constants, and COL_W/ROW_W width constants.
- One sub-module: piece_collision_scan. Inputs are the candidate col/row/mask and a start strobe. It drives the occ_rd_* interface and outputs done/blocked.

Test Plan:
1. Empty board (occ_rd_data=0), spawn_mask=0x038 -> piece_active=1, ref_x=64, ref_y=16, blockNeighbors=0x038.
2. Then cmd_rot -> after busy falls, blockNeighbors=0x092, ref unchanged. A second cmd_rot -> 0x038.
3. Mask 0x092 at col 4, four cmd_left pulses -> col 3, 2, 1 each commit. The fourth is blocked (col -1): ref_x stays 16, no lock_valid.
4. cmd_left and cmd_right in the same cycle at col 4 -> left served first (col 3), then right (col 4). Final ref_x=64.
5. GRAVITY_TICKS=8, mask 0x038, empty board -> row steps to 18, then the down is blocked by row 20 -> single lock_valid pulse with lock_col=4, lock_row=18, lock_mask=0x038, piece_active=0.
6. occ_rd_data=1 for cell (4,1), spawn_req -> game_over=1, piece_active=0, later commands ignored. resetn low mid-CHECK -> occ_rd_en=0 and busy=0 immediately.
